// File: rtl/cpu_counter_pkg.sv
// Shared types for the tick counter slice: control FSM encoding and default width.
package cpu_counter_pkg;
  typedef enum logic [1:0] {
    STOP  = 2'd0,
    RUN   = 2'd1,
    CLEAR = 2'd2
  } state_e;

  localparam int DIGITS_DEF = 4;
endpackage

// File: rtl/bcd_digit.sv
// One decade of the BCD cascade; o_co flags that this digit is rolling over on this enable.
module bcd_digit (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_en,
  input  logic       i_down,
  input  logic       i_clr,
  output logic [3:0] o_digit,
  output logic       o_co
);
  logic [3:0] r_digit;

  assign o_digit = r_digit;
  assign o_co    = i_en & (i_down ? (r_digit == 4'd0) : (r_digit == 4'd9));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       r_digit <= 4'd0;
    else if (i_clr)  r_digit <= 4'd0;
    else if (i_en) begin
      if (i_down) r_digit <= (r_digit == 4'd0) ? 4'd9 : r_digit - 4'd1;
      else        r_digit <= (r_digit == 4'd9) ? 4'd0 : r_digit + 4'd1;
    end
  end
endmodule

// File: rtl/tick_counter_ctrl.sv
// Run/stop/clear controlled decimal event counter driven by the divider tick.
// Binary and BCD counters advance in lockstep from the same enable.
module tick_counter_ctrl
  import cpu_counter_pkg::*;
#(
  parameter  int DIGITS    = DIGITS_DEF,
  localparam int MAX_COUNT = 10**DIGITS - 1,
  localparam int CW        = $clog2(MAX_COUNT + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_tick,
  input  logic                i_btn_run_stop,
  input  logic                i_btn_clear,
  input  logic                i_mode_down,
  output logic [CW-1:0]       o_count,
  output logic [4*DIGITS-1:0] o_bcd,
  output logic                o_run,
  output logic                o_wrap
);
  localparam logic [CW-1:0] MAX_CW = CW'(MAX_COUNT);

  state_e        r_state;
  state_e        w_next;
  logic          r_rs_prev, r_clr_prev;
  logic          w_rs_edge, w_clr_edge;
  logic          w_cnt_en, w_clr;
  logic [CW-1:0] r_count;
  logic [DIGITS:0]   w_dig_en;
  logic [DIGITS-1:0] w_co;

  assign w_rs_edge  = i_btn_run_stop & ~r_rs_prev;
  assign w_clr_edge = i_btn_clear & ~r_clr_prev;

  always_comb begin
    w_next = r_state;
    case (r_state)
      STOP:    if (w_clr_edge) w_next = CLEAR;
               else if (w_rs_edge) w_next = RUN;
      RUN:     if (w_rs_edge) w_next = STOP;
      CLEAR:   w_next = STOP;
      default: w_next = STOP;
    endcase
  end

  // The current state governs counting, so a tick alongside the stopping edge still counts.
  assign w_cnt_en = (r_state == RUN) & i_tick;
  // Zero on entry to CLEAR so the count reads 0 the cycle after the clear edge.
  assign w_clr    = (w_next == CLEAR);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= STOP;
      r_rs_prev  <= 1'b0;
      r_clr_prev <= 1'b0;
      o_run      <= 1'b0;
      o_wrap     <= 1'b0;
      r_count    <= '0;
    end else begin
      r_state    <= w_next;
      r_rs_prev  <= i_btn_run_stop;
      r_clr_prev <= i_btn_clear;
      o_run      <= (w_next == RUN);
      o_wrap     <= w_co[DIGITS-1];
      if (w_clr) r_count <= '0;
      else if (w_cnt_en) begin
        if (i_mode_down) r_count <= (r_count == '0) ? MAX_CW : r_count - 1'b1;
        else             r_count <= (r_count == MAX_CW) ? '0 : r_count + 1'b1;
      end
    end
  end

  assign w_dig_en[0] = w_cnt_en;

  genvar g;
  generate
    for (g = 0; g < DIGITS; g++) begin : g_dig
      bcd_digit u_dig (
        .clk     (clk),
        .reset   (reset),
        .i_en    (w_dig_en[g]),
        .i_down  (i_mode_down),
        .i_clr   (w_clr),
        .o_digit (o_bcd[4*g +: 4]),
        .o_co    (w_co[g])
      );
      assign w_dig_en[g+1] = w_co[g];
    end
  endgenerate

  assign o_count = r_count;

  function automatic logic [4*DIGITS-1:0] to_bcd(input logic [CW-1:0] v);
    int t;
    to_bcd = '0;
    t = int'(v);
    for (int i = 0; i < DIGITS; i++) begin
      to_bcd[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
  endfunction

  always @(posedge clk) begin
    if (!reset)
      assert (r_count <= MAX_CW && to_bcd(r_count) == o_bcd)
        else $error("binary/BCD disagree: %0d vs %h", r_count, o_bcd);
  end
endmodule

// File: tb/tb_tick_counter_ctrl.sv
// Directed bench for tick_counter_ctrl; a cycle model queues expected outputs per clock.
module tb_tick_counter_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic        i_tick, i_btn_run_stop, i_btn_clear, i_mode_down;
  logic [13:0] o_count;
  logic [15:0] o_bcd;
  logic        o_run, o_wrap;

  typedef struct packed {
    logic [13:0] count;
    logic [15:0] bcd;
    logic        run;
    logic        wrap;
  } exp_t;

  exp_t exp_q[$];
  int total = 0;
  int bad   = 0;

  // model state
  int m_cnt;
  int m_st;        // 0 stop, 1 run, 2 clear
  bit m_rs_prev, m_clr_prev;

  tick_counter_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .i_tick         (i_tick),
    .i_btn_run_stop (i_btn_run_stop),
    .i_btn_clear    (i_btn_clear),
    .i_mode_down    (i_mode_down),
    .o_count        (o_count),
    .o_bcd          (o_bcd),
    .o_run          (o_run),
    .o_wrap         (o_wrap)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] dec(input int v);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] expv);
    total++;
    assert (got === expv) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, expv);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_st = 0; m_rs_prev = 0; m_clr_prev = 0;
  endtask

  // One clock: drive inputs at negedge, queue model result, compare after the edge.
  task automatic step(input bit t, input bit rs, input bit clr, input bit dn);
    exp_t e;
    bit rs_e, clr_e, counted;
    int nx;
    @(negedge clk);
    i_tick = t; i_btn_run_stop = rs; i_btn_clear = clr; i_mode_down = dn;
    rs_e  = rs & ~m_rs_prev;
    clr_e = clr & ~m_clr_prev;
    m_rs_prev = rs; m_clr_prev = clr;
    counted = (m_st == 1) && t;
    case (m_st)
      0: nx = clr_e ? 2 : (rs_e ? 1 : 0);
      1: nx = rs_e ? 0 : 1;
      default: nx = 0;
    endcase
    e.wrap = 1'b0;
    if (nx == 2) m_cnt = 0;
    else if (counted) begin
      if (dn) begin
        e.wrap = (m_cnt == 0);
        m_cnt  = (m_cnt == 0) ? 9999 : m_cnt - 1;
      end else begin
        e.wrap = (m_cnt == 9999);
        m_cnt  = (m_cnt == 9999) ? 0 : m_cnt + 1;
      end
    end
    m_st    = nx;
    e.count = 14'(m_cnt);
    e.bcd   = dec(m_cnt);
    e.run   = (nx == 1);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk("count", 16'(o_count), 16'(e.count));
    chk("bcd",   o_bcd,        e.bcd);
    chk("run",   16'(o_run),   16'(e.run));
    chk("wrap",  16'(o_wrap),  16'(e.wrap));
  endtask

  task automatic tick1(input bit dn);
    step(1, 0, 0, dn);
    step(0, 0, 0, dn);
  endtask

  task automatic press_rs();
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
  endtask

  task automatic press_clr();
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
  endtask

  initial begin
    int guard;
    i_tick = 0; i_btn_run_stop = 0; i_btn_clear = 0; i_mode_down = 0;
    reset = 1'b1;
    model_reset();
    #12;
    chk("rst_count", 16'(o_count), 16'd0);
    chk("rst_bcd",   o_bcd,        16'h0000);
    chk("rst_run",   16'(o_run),   16'd0);
    @(negedge clk); reset = 1'b0;

    // ticks in STOP do nothing
    repeat (3) tick1(0);

    // run and count 12
    press_rs();
    repeat (12) tick1(0);
    chk("cnt12", 16'(o_count), 16'd12);
    chk("bcd12", o_bcd,        16'h0012);
    chk("run12", 16'(o_run),   16'd1);
    press_rs();
    repeat (5) tick1(0);
    chk("held12", 16'(o_count), 16'd12);

    // advance to 9998, then wrap up and wrap down
    press_rs();
    repeat (9998 - 12) tick1(0);
    chk("at9998", 16'(o_count), 16'd9998);
    tick1(0);
    step(1, 0, 0, 0);
    chk("wrap_up_cnt", 16'(o_count), 16'd0);
    chk("wrap_up_pls", 16'(o_wrap),  16'd1);
    step(0, 0, 0, 0);
    step(1, 0, 0, 1);
    chk("wrap_dn_cnt", o_bcd,       16'h9999);
    chk("wrap_dn_pls", 16'(o_wrap), 16'd1);
    step(0, 0, 0, 1);
    // direction flip between ticks
    tick1(0);
    tick1(0);
    tick1(1);

    // clear ignored in RUN, honoured in STOP
    press_clr();
    tick1(0);
    tick1(0);
    chk("clr_ign", 16'(o_count), 16'd2);
    press_rs();
    step(0, 0, 1, 0);
    chk("clr_cnt", 16'(o_count), 16'd0);
    chk("clr_run", 16'(o_run),   16'd0);
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);

    // tick coincident with run/stop edge
    press_rs();
    tick1(0);
    step(1, 1, 0, 0);
    chk("rs_tick_run", 16'(o_count), 16'd2);
    chk("rs_tick_off", 16'(o_run),   16'd0);
    step(0, 0, 0, 0);
    step(1, 1, 0, 0);
    chk("rs_tick_stp", 16'(o_count), 16'd2);
    chk("rs_tick_on",  16'(o_run),   16'd1);
    step(0, 0, 0, 0);

    // count up to 0347, then reset mid-run
    guard = 0;
    while (m_cnt != 347 && guard < 10000) begin
      tick1(0);
      guard++;
    end
    chk("at347", o_bcd, 16'h0347);
    #2;
    reset = 1'b1;
    i_btn_run_stop = 1'b1;
    #1;
    chk("mid_rst_cnt", 16'(o_count), 16'd0);
    chk("mid_rst_bcd", o_bcd,        16'h0000);
    chk("mid_rst_run", 16'(o_run),   16'd0);
    model_reset();
    @(negedge clk); reset = 1'b0;
    step(0, 1, 0, 0);
    chk("rel_run", 16'(o_run), 16'd1);
    step(1, 1, 0, 0);
    step(0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
